counter_multimode: RTL and testbench

//  Parametrised successor to the single-mode linear counter. Provides up, down,

---
 rtl/counter_multimode.sv | 237 +++++++++++++++++++++++
 tb/tb_counter_multimode.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_multimode.sv
// Purpose : multi-mode counter (UP / DOWN / UPDOWN ping-pong / ONESHOT) against a runtime modulus.
// Latency : count/dir/done update on the clock edge after enb is sampled; tc and pre_tc are combinational.
// Backpres: none; one step per enabled cycle, cascade by driving the next stage's enb from tc.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous reset, active low
//   enb       in   1      count enable, one step per cycle when high
//   sync_clr  in   1      synchronous clear, highest priority, ignores enb
//   load      in   1      synchronous parallel load, ignores enb
//   load_val  in   WIDTH  value to load, clamped to max_val
//   max_val   in   WIDTH  runtime modulus; count range is 0..max_val
//   mode      in   2      00 UP, 01 DOWN, 10 UPDOWN, 11 ONESHOT
//   count     out  WIDTH  current count (registered)
//   dir       out  1      current direction, 0 = up, 1 = down (registered)
//   done      out  1      ONESHOT finished, sticky until clear/load/mode change (registered)
//   tc        out  1      enb while the count sits on its terminal value (comb)
//   pre_tc    out  1      count is PRE_TC_DIST steps short of terminal (comb, independent of enb)

module counter_multimode #(
  parameter int WIDTH       = 4,
  parameter int PRE_TC_DIST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             done,
  output logic             tc,
  output logic             pre_tc
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_multimode: WIDTH must be in 1..32");
  end
  if (PRE_TC_DIST < 0) begin : g_bad_pre_tc_dist
    $error("counter_multimode: PRE_TC_DIST must be non-negative");
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_UPDOWN  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  // The distance is only used once it is known to fit under max_val, so the
  // truncated copy is exact wherever it matters.
  localparam int unsigned      DIST   = PRE_TC_DIST;
  localparam logic [WIDTH-1:0] DIST_W = WIDTH'(PRE_TC_DIST);

  // ---------------------------------------------------------------------------
  // Shared comparisons
  // ---------------------------------------------------------------------------
  logic at_max;     // sitting exactly on the modulus
  logic over_max;   // modulus was lowered underneath the count
  logic at_zero;
  logic max_zero;   // degenerate single-value range

  assign at_max   = (count == max_val);
  assign over_max = (count >  max_val);
  assign at_zero  = (count == ZERO);
  assign max_zero = (max_val == ZERO);

  // pre_tc is suppressed when disabled or when the distance cannot fit in the
  // current range (it would otherwise alias onto an unrelated count value).
  logic pre_en;
  logic pre_up;     // DIST steps below max_val, counting up
  logic pre_down;   // DIST steps above zero, counting down

  assign pre_en   = (DIST != 0) && (32'(max_val) >= DIST);
  assign pre_up   = pre_en && (count == (max_val - DIST_W));
  assign pre_down = pre_en && (count == DIST_W);

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic             done_nxt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      dir   <= dir_nxt;
      done  <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // Priority: sync_clr > load > enabled step > hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    done_nxt  = done;

    // Direction is implied by the mode everywhere except ping-pong, so it is
    // re-asserted on every edge; this is what realigns dir after a mode change.
    case (mode)
      MODE_UP,
      MODE_ONESHOT: dir_nxt = 1'b0;
      MODE_DOWN:    dir_nxt = 1'b1;
      default:      dir_nxt = dir;
    endcase

    // done only has meaning inside ONESHOT.
    if (mode != MODE_ONESHOT) begin
      done_nxt = 1'b0;
    end

    if (sync_clr) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
      dir_nxt   = (mode == MODE_DOWN);
    end else if (load) begin
      // Clamp so the count <= max_val invariant survives an out-of-range load.
      count_nxt = (load_val > max_val) ? max_val : load_val;
      done_nxt  = 1'b0;
    end else if (enb) begin
      case (mode)
        MODE_UP: begin
          // over_max: modulus dropped below count -> same action as terminal.
          if (at_max || over_max) begin
            count_nxt = '0;
          end else begin
            count_nxt = count + ONE;
          end
        end

        MODE_DOWN: begin
          if (at_zero || over_max) begin
            count_nxt = max_val;
          end else begin
            count_nxt = count - ONE;
          end
        end

        MODE_UPDOWN: begin
          if (max_zero) begin
            // Only one legal value: every step is a turnaround with count pinned.
            count_nxt = '0;
            dir_nxt   = ~dir;
          end else if (over_max) begin
            // Re-enter the range at the top, heading down.
            count_nxt = max_val;
            dir_nxt   = 1'b1;
          end else if (!dir) begin
            if (at_max) begin
              // Turnaround: the peak is shown once, next value is one below it.
              count_nxt = max_val - ONE;
              dir_nxt   = 1'b1;
            end else begin
              count_nxt = count + ONE;
            end
          end else begin
            if (at_zero) begin
              count_nxt = ONE;
              dir_nxt   = 1'b0;
            end else begin
              count_nxt = count - ONE;
            end
          end
        end

        default: begin // MODE_ONESHOT
          // Once done, the counter is frozen until clear, load or mode change.
          if (!done) begin
            if (at_max || over_max) begin
              count_nxt = max_val;
              done_nxt  = 1'b1;
            end else begin
              count_nxt = count + ONE;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // tc is gated by enb so that a chain of stages advances together: stage N+1
  // steps exactly on the cycle stage N wraps.
  // ---------------------------------------------------------------------------
  logic term;
  logic pre;

  always_comb begin
    term = 1'b0;
    pre  = 1'b0;
    case (mode)
      MODE_UP: begin
        term = at_max;
        pre  = pre_up;
      end
      MODE_DOWN: begin
        term = at_zero;
        pre  = pre_down;
      end
      MODE_UPDOWN: begin
        term = dir ? at_zero  : at_max;
        pre  = dir ? pre_down : pre_up;
      end
      default: begin // MODE_ONESHOT
        // Single pulse: suppressed once done has latched.
        term = at_max && !done;
        pre  = pre_up;
      end
    endcase
  end

  assign tc     = enb && term;
  assign pre_tc = pre;

endmodule

// File: tb/tb_counter_multimode.sv
module tb_counter_multimode;

  localparam logic [1:0] M_UP = 2'b00;
  localparam logic [1:0] M_DN = 2'b01;
  localparam logic [1:0] M_UD = 2'b10;
  localparam logic [1:0] M_OS = 2'b11;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       sync_clr;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] max_val;
  logic [1:0] mode;
  logic [3:0] count;
  logic       dir;
  logic       done;
  logic       tc;
  logic       pre_tc;

  int errors = 0;
  int checks = 0;

  // Expected values for one step: registered state after the edge, and the
  // combinational outputs during the cycle before it.
  typedef struct packed {
    logic [3:0] cnt;
    logic       dr;
    logic       dn;
    logic       t;
    logic       p;
  } exp_t;

  exp_t sb[$];

  counter_multimode #(
    .WIDTH       (4),
    .PRE_TC_DIST (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .sync_clr (sync_clr),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .mode     (mode),
    .count    (count),
    .dir      (dir),
    .done     (done),
    .tc       (tc),
    .pre_tc   (pre_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic set_in(input logic [1:0] m, input logic [3:0] mx, input logic en,
                        input logic clr, input logic ld, input logic [3:0] lv);
    mode     = m;
    max_val  = mx;
    enb      = en;
    sync_clr = clr;
    load     = ld;
    load_val = lv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(M_UP, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks += 5;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b want 0", dir); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", tc); end
    if (pre_tc !== 1'b0) begin errors++; $display("FAIL reset_pre_tc: got %b want 0", pre_tc); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_up();
    exp_t e;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      set_in(M_UP, 4'd9, 1'b1, 1'b0, 1'b0, 4'd0);
      sb.push_back('{cnt: 4'((i + 1) % 10), dr: 1'b0, dn: 1'b0,
                     t: ((i % 10) == 9), p: ((i % 10) == 8)});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (tc !== e.t) begin errors++; $display("FAIL up_tc step %0d: got %b want %b", i, tc, e.t); end
      if (pre_tc !== e.p) begin errors++; $display("FAIL up_pre_tc step %0d: got %b want %b", i, pre_tc, e.p); end
      @(posedge clk);
      #1;
      checks += 3;
      if (count !== e.cnt) begin errors++; $display("FAIL up_count step %0d: got %0d want %0d", i, count, e.cnt); end
      if (dir !== e.dr) begin errors++; $display("FAIL up_dir step %0d: got %b want %b", i, dir, e.dr); end
      if (done !== e.dn) begin errors++; $display("FAIL up_done step %0d: got %b want %b", i, done, e.dn); end
    end
  endtask

  task automatic test_down();
    exp_t e;
    logic [3:0] pre_c [7] = '{4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic [3:0] post_c [7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_in(M_DN, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
      sb.push_back('{cnt: post_c[i], dr: 1'b1, dn: 1'b0,
                     t: (pre_c[i] == 4'd0), p: (pre_c[i] == 4'd1)});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (tc !== e.t) begin errors++; $display("FAIL down_tc step %0d: got %b want %b", i, tc, e.t); end
      if (pre_tc !== e.p) begin errors++; $display("FAIL down_pre_tc step %0d: got %b want %b", i, pre_tc, e.p); end
      @(posedge clk);
      #1;
      checks += 3;
      if (count !== e.cnt) begin errors++; $display("FAIL down_count step %0d: got %0d want %0d", i, count, e.cnt); end
      if (dir !== e.dr) begin errors++; $display("FAIL down_dir step %0d: got %b want %b", i, dir, e.dr); end
      if (done !== e.dn) begin errors++; $display("FAIL down_done step %0d: got %b want %b", i, done, e.dn); end
    end
  endtask

  task automatic test_updown();
    exp_t e;
    logic [3:0] cs [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
    logic       ds [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       ts [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ps [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(M_UD, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
      sb.push_back('{cnt: cs[i+1], dr: ds[i+1], dn: 1'b0, t: ts[i], p: ps[i]});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (tc !== e.t) begin errors++; $display("FAIL updown_tc step %0d: got %b want %b", i, tc, e.t); end
      if (pre_tc !== e.p) begin errors++; $display("FAIL updown_pre_tc step %0d: got %b want %b", i, pre_tc, e.p); end
      @(posedge clk);
      #1;
      checks += 3;
      if (count !== e.cnt) begin errors++; $display("FAIL updown_count step %0d: got %0d want %0d", i, count, e.cnt); end
      if (dir !== e.dr) begin errors++; $display("FAIL updown_dir step %0d: got %b want %b", i, dir, e.dr); end
      if (done !== e.dn) begin errors++; $display("FAIL updown_done step %0d: got %b want %b", i, done, e.dn); end
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    int   tc_seen = 0;
    // Steps 0..6 hold enb; step 7 loads 2 with enb low.
    logic       ld [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] cs [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd2};
    logic       dn [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       ps [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(M_OS, 4'd4, !ld[i], 1'b0, ld[i], 4'd2);
      sb.push_back('{cnt: cs[i], dr: 1'b0, dn: dn[i], t: ts[i], p: ps[i]});
      #1;
      e = sb.pop_front();
      if (tc === 1'b1) tc_seen++;
      checks += 2;
      if (tc !== e.t) begin errors++; $display("FAIL oneshot_tc step %0d: got %b want %b", i, tc, e.t); end
      if (pre_tc !== e.p) begin errors++; $display("FAIL oneshot_pre_tc step %0d: got %b want %b", i, pre_tc, e.p); end
      @(posedge clk);
      #1;
      checks += 3;
      if (count !== e.cnt) begin errors++; $display("FAIL oneshot_count step %0d: got %0d want %0d", i, count, e.cnt); end
      if (dir !== e.dr) begin errors++; $display("FAIL oneshot_dir step %0d: got %b want %b", i, dir, e.dr); end
      if (done !== e.dn) begin errors++; $display("FAIL oneshot_done step %0d: got %b want %b", i, done, e.dn); end
    end
    checks++;
    if (tc_seen !== 1) begin errors++; $display("FAIL oneshot_tc_pulses: got %0d want 1", tc_seen); end
  endtask

  // Per mode: idle (mode settles), load 7 under max 9, then step with max 5.
  task automatic test_max_lowered();
    exp_t e;
    logic [1:0] md [13] = '{M_UP, M_UP, M_UP, M_DN, M_DN, M_DN, M_UD, M_UD, M_UD,
                            M_OS, M_OS, M_OS, M_UP};
    logic [3:0] mx [13] = '{4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd5,
                            4'd9, 4'd9, 4'd5, 4'd5};
    logic       en [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b0};
    logic       ld [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] lv [13] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7,
                            4'd7, 4'd7, 4'd7, 4'd12};
    logic [3:0] cs [13] = '{4'd2, 4'd7, 4'd0, 4'd0, 4'd7, 4'd5, 4'd5, 4'd7, 4'd5,
                            4'd5, 4'd7, 4'd5, 4'd5};
    logic       ds [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0};
    logic       dn [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      set_in(md[i], mx[i], en[i], 1'b0, ld[i], lv[i]);
      sb.push_back('{cnt: cs[i], dr: ds[i], dn: dn[i], t: 1'b0, p: 1'b0});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (tc !== e.t) begin errors++; $display("FAIL lowered_tc step %0d: got %b want %b", i, tc, e.t); end
      if (pre_tc !== e.p) begin errors++; $display("FAIL lowered_pre_tc step %0d: got %b want %b", i, pre_tc, e.p); end
      @(posedge clk);
      #1;
      checks += 3;
      if (count !== e.cnt) begin errors++; $display("FAIL lowered_count step %0d: got %0d want %0d", i, count, e.cnt); end
      if (dir !== e.dr) begin errors++; $display("FAIL lowered_dir step %0d: got %b want %b", i, dir, e.dr); end
      if (done !== e.dn) begin errors++; $display("FAIL lowered_done step %0d: got %b want %b", i, done, e.dn); end
    end
  endtask

  // max_val = 0 in UP/DOWN/ONESHOT, then max_val = 1 ping-pong.
  task automatic test_boundary();
    exp_t e;
    logic [1:0] md [10] = '{M_UP, M_UP, M_UP, M_DN, M_OS, M_OS, M_UD, M_UD, M_UD, M_UD};
    logic [3:0] mx [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    logic [3:0] cs [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    logic       ds [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       dn [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ts [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       ps [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_in(md[i], mx[i], 1'b1, 1'b0, 1'b0, 4'd0);
      sb.push_back('{cnt: cs[i], dr: ds[i], dn: dn[i], t: ts[i], p: ps[i]});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (tc !== e.t) begin errors++; $display("FAIL boundary_tc step %0d: got %b want %b", i, tc, e.t); end
      if (pre_tc !== e.p) begin errors++; $display("FAIL boundary_pre_tc step %0d: got %b want %b", i, pre_tc, e.p); end
      @(posedge clk);
      #1;
      checks += 3;
      if (count !== e.cnt) begin errors++; $display("FAIL boundary_count step %0d: got %0d want %0d", i, count, e.cnt); end
      if (dir !== e.dr) begin errors++; $display("FAIL boundary_dir step %0d: got %b want %b", i, dir, e.dr); end
      if (done !== e.dn) begin errors++; $display("FAIL boundary_done step %0d: got %b want %b", i, done, e.dn); end
    end
  endtask

  // sync_clr priority over load/enb, then async reset mid ping-pong.
  task automatic test_clr_load_reset();
    exp_t e;
    logic [1:0] md [9] = '{M_UD, M_UD, M_DN, M_OS, M_OS, M_UD, M_UD, M_UD, M_UD};
    logic [3:0] mx [9] = '{4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd3, 4'd3, 4'd3, 4'd3};
    logic       en [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       cl [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ld [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] lv [9] = '{4'd6, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] cs [9] = '{4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2};
    logic       ds [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       dn [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ts [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ps [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_in(md[i], mx[i], en[i], cl[i], ld[i], lv[i]);
      sb.push_back('{cnt: cs[i], dr: ds[i], dn: dn[i], t: ts[i], p: ps[i]});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (tc !== e.t) begin errors++; $display("FAIL clr_tc step %0d: got %b want %b", i, tc, e.t); end
      if (pre_tc !== e.p) begin errors++; $display("FAIL clr_pre_tc step %0d: got %b want %b", i, pre_tc, e.p); end
      @(posedge clk);
      #1;
      checks += 3;
      if (count !== e.cnt) begin errors++; $display("FAIL clr_count step %0d: got %0d want %0d", i, count, e.cnt); end
      if (dir !== e.dr) begin errors++; $display("FAIL clr_dir step %0d: got %b want %b", i, dir, e.dr); end
      if (done !== e.dn) begin errors++; $display("FAIL clr_done step %0d: got %b want %b", i, done, e.dn); end
    end

    // Now count = 2, dir = 1. Pull reset mid-cycle, well away from any edge.
    @(negedge clk);
    set_in(M_UD, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    sb.push_back('{cnt: 4'd0, dr: 1'b0, dn: 1'b0, t: 1'b0, p: 1'b0});
    #2;
    rst = 1'b0;
    #1;
    e = sb.pop_front();
    checks += 2;
    if (count !== e.cnt) begin errors++; $display("FAIL async_rst_count: got %0d want %0d", count, e.cnt); end
    if (dir !== e.dr) begin errors++; $display("FAIL async_rst_dir: got %b want %b", dir, e.dr); end
    @(posedge clk);
    #1;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL rst_hold_count: got %0d want 0", count); end
    @(negedge clk);
    rst = 1'b1;
    enb = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    set_in(M_UP, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    test_reset();
    test_up();
    test_down();
    test_updown();
    test_oneshot();
    test_max_lowered();
    test_boundary();
    test_clr_load_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
